// File: rtl/freq_nco_pkg.sv
// Shared types and constants for the frequency NCO: state encoding, increment
// scaling and the default/clamp frequencies.
package freq_nco_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } nco_state_e;

    localparam int unsigned INC_SHIFT = 24;

    localparam logic [31:0] F_DEFAULT_HZ = 32'h0000_9C40;
    localparam logic [31:0] F_MIN_HZ     = 32'd20000;
    localparam logic [31:0] F_MAX_HZ     = 32'd60000;

    // round(2^56 / fclk): phase step per Hz, pre-scaled by 2^24
    function automatic logic [31:0] calc_inc_k(input logic [63:0] fclk_hz);
        logic [63:0] num;
        num = 64'd1 << 56;
        return 32'((num + (fclk_hz >> 1)) / fclk_hz);
    endfunction

    function automatic logic [31:0] calc_inc(input logic [31:0] f_hz, input logic [31:0] inc_k);
        logic [63:0] prod;
        prod = 64'(f_hz) * 64'(inc_k);
        return prod[INC_SHIFT +: 32];
    endfunction

endpackage

// File: rtl/freq_nco_if.sv
// Control and status bundle between the loop-filter side and the NCO.
interface freq_nco_if;
    logic        swiptAlive;
    logic [31:0] f;
    logic        vco;
    logic        vco_rise;
    logic [31:0] f_applied;
    logic        clamped;
    logic [31:0] period;
    logic        period_valid;

    modport master (
        output swiptAlive, f,
        input  vco, vco_rise, f_applied, clamped, period, period_valid
    );

    modport slave (
        input  swiptAlive, f,
        output vco, vco_rise, f_applied, clamped, period, period_valid
    );
endinterface

// File: rtl/freq_nco_inc_calc.sv
// Three-stage request pipeline: register f, clamp to [F_MIN, F_MAX], then
// convert the clamped frequency into a 32-bit phase increment.
module nco_inc_calc
    import freq_nco_pkg::*;
#(
    parameter int unsigned FCLK_HZ   = 100_000_000,
    parameter logic [31:0] F_DEFAULT = F_DEFAULT_HZ,
    parameter logic [31:0] F_MIN     = F_MIN_HZ,
    parameter logic [31:0] F_MAX     = F_MAX_HZ
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] f,
    output logic [31:0] f_clamped,
    output logic        clamped,
    output logic [31:0] inc_next
);

    localparam logic [31:0] INC_K       = calc_inc_k(64'(FCLK_HZ));
    localparam logic [31:0] INC_DEFAULT = calc_inc(F_DEFAULT, INC_K);

    logic [31:0] f_req_q, f_req_d;
    logic [31:0] f_lim_q, f_lim_d;
    logic [31:0] f_lim_dly_q, f_lim_dly_d;
    logic        clamped_q, clamped_d;
    logic [31:0] inc_next_q, inc_next_d;

    // NOTE: every signal written here gets a default before any branch, so no latch can be inferred.
    always_comb begin
        f_req_d   = f;
        f_lim_d   = f_req_q;
        clamped_d = 1'b0;
        if (f_req_q < F_MIN) begin
            f_lim_d   = F_MIN;
            clamped_d = 1'b1;
        end else if (f_req_q > F_MAX) begin
            f_lim_d   = F_MAX;
            clamped_d = 1'b1;
        end
        // Delay the clamped value one stage so it stays paired with its increment
        f_lim_dly_d = f_lim_q;
        inc_next_d  = calc_inc(f_lim_q, INC_K);
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            f_req_q     <= F_DEFAULT;
            f_lim_q     <= F_DEFAULT;
            f_lim_dly_q <= F_DEFAULT;
            clamped_q   <= 1'b0;
            inc_next_q  <= INC_DEFAULT;
        end else begin
            f_req_q     <= f_req_d;
            f_lim_q     <= f_lim_d;
            f_lim_dly_q <= f_lim_dly_d;
            clamped_q   <= clamped_d;
            inc_next_q  <= inc_next_d;
        end
    end

    assign f_clamped = f_lim_dly_q;
    assign clamped   = clamped_q;
    assign inc_next  = inc_next_q;

endmodule

// File: rtl/freq_nco.sv
// Phase-accumulator NCO with glitch-free start/stop, wrap-aligned frequency
// updates and a rise-to-rise period measurement.
module freq_nco
    import freq_nco_pkg::*;
#(
    parameter int unsigned FCLK_HZ   = 100_000_000,
    parameter logic [31:0] F_DEFAULT = F_DEFAULT_HZ,
    parameter logic [31:0] F_MIN     = F_MIN_HZ,
    parameter logic [31:0] F_MAX     = F_MAX_HZ
) (
    input  logic       clk,
    input  logic       nrst,
    freq_nco_if.slave  bus
);

    localparam logic [31:0] INC_DEFAULT = calc_inc(F_DEFAULT, calc_inc_k(64'(FCLK_HZ)));

    logic [31:0] inc_next;
    logic [31:0] f_clamped;
    logic        clamped;

    nco_inc_calc #(
        .FCLK_HZ   (FCLK_HZ),
        .F_DEFAULT (F_DEFAULT),
        .F_MIN     (F_MIN),
        .F_MAX     (F_MAX)
    ) u_inc_calc (
        .clk       (clk),
        .nrst      (nrst),
        .f         (bus.f),
        .f_clamped (f_clamped),
        .clamped   (clamped),
        .inc_next  (inc_next)
    );

    nco_state_e  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] inc_q, inc_d;
    logic [31:0] f_applied_q, f_applied_d;
    logic        vco_rise_q, vco_rise_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        period_valid_q, period_valid_d;
    logic        rise_seen_q, rise_seen_d;
    logic [32:0] acc_sum;
    logic        wrap;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        inc_d          = inc_q;
        f_applied_d    = f_applied_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        rise_seen_d    = rise_seen_q;
        acc_sum        = {1'b0, acc_q} + {1'b0, inc_q};
        wrap           = acc_sum[32];

        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                if (bus.swiptAlive) begin
                    state_d     = RUN;
                    inc_d       = inc_next;
                    f_applied_d = f_clamped;
                end
            end
            RUN: begin
                acc_d = acc_sum[31:0];
                if (wrap) begin
                    inc_d       = inc_next;
                    f_applied_d = f_clamped;
                end
                if (!bus.swiptAlive) state_d = STOP;
            end
            STOP: begin
                // A wrap ends the stop even if swiptAlive came back this cycle
                if (wrap) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_sum[31:0];
                    if (bus.swiptAlive) state_d = RUN;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = IDLE;
            end
        endcase

        vco_rise_d = acc_d[31] & ~acc_q[31];

        // The first rise after IDLE closes a partial cycle, so only the second one validates
        if (state_d == IDLE) begin
            cnt_d          = '0;
            period_valid_d = 1'b0;
            rise_seen_d    = 1'b0;
        end else if (vco_rise_q) begin
            period_d    = cnt_q;
            cnt_d       = 32'd1;
            rise_seen_d = 1'b1;
            if (rise_seen_q) period_valid_d = 1'b1;
        end else if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            inc_q          <= INC_DEFAULT;
            f_applied_q    <= F_DEFAULT;
            vco_rise_q     <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            rise_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            inc_q          <= inc_d;
            f_applied_q    <= f_applied_d;
            vco_rise_q     <= vco_rise_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            rise_seen_q    <= rise_seen_d;
        end
    end

    assign bus.vco          = acc_q[31];
    assign bus.vco_rise     = vco_rise_q;
    assign bus.f_applied    = f_applied_q;
    assign bus.clamped      = clamped;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;

endmodule

// File: tb/tb_freq_nco.sv
// Self-checking bench for freq_nco: vector table with a scoreboard queue plus
// hand-written start/stop/reset sequences.
module tb_freq_nco;
    import freq_nco_pkg::*;

    localparam logic [31:0] INC_40K = 32'd1717986;
    localparam logic [31:0] INC_50K = 32'd2147483;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    freq_nco_if bus ();

    freq_nco #(
        .FCLK_HZ   (100_000_000),
        .F_DEFAULT (32'h0000_9C40),
        .F_MIN     (32'd20000),
        .F_MAX     (32'd60000)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] f;
        logic [31:0] exp_applied;
        logic        exp_clamped;
        bit          chk_period;
        int          lo;
        int          hi;
    } vec_t;

    vec_t vecs [8];
    vec_t exp_q [$];
    vec_t cur;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rise(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.vco_rise === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_applied(input string name, input logic [31:0] exp, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.f_applied === exp) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, bus.f_applied, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " vco"}, 32'(bus.vco), 32'd0);
        check({tag, " vco_rise"}, 32'(bus.vco_rise), 32'd0);
        check({tag, " f_applied"}, bus.f_applied, 32'd40000);
        check({tag, " clamped"}, 32'(bus.clamped), 32'd0);
        check({tag, " period"}, bus.period, 32'd0);
        check({tag, " period_valid"}, 32'(bus.period_valid), 32'd0);
        check({tag, " state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        int hi_cnt;
        bit early_change;
        bit cont_ok;
        bit quiet;
        logic [31:0] prev_acc;

        vecs[0] = '{f: 32'd0,     exp_applied: 32'd20000, exp_clamped: 1'b1, chk_period: 1'b1, lo: 4999, hi: 5001};
        vecs[1] = '{f: 32'd70000, exp_applied: 32'd60000, exp_clamped: 1'b1, chk_period: 1'b1, lo: 1666, hi: 1667};
        vecs[2] = '{f: 32'd50000, exp_applied: 32'd50000, exp_clamped: 1'b0, chk_period: 1'b1, lo: 1999, hi: 2001};
        vecs[3] = '{f: 32'd60000, exp_applied: 32'd60000, exp_clamped: 1'b0, chk_period: 1'b1, lo: 1666, hi: 1667};
        vecs[4] = '{f: 32'd20000, exp_applied: 32'd20000, exp_clamped: 1'b0, chk_period: 1'b0, lo: 0,    hi: 0};
        vecs[5] = '{f: 32'd19999, exp_applied: 32'd20000, exp_clamped: 1'b1, chk_period: 1'b0, lo: 0,    hi: 0};
        vecs[6] = '{f: 32'd60001, exp_applied: 32'd60000, exp_clamped: 1'b1, chk_period: 1'b0, lo: 0,    hi: 0};
        vecs[7] = '{f: 32'd40000, exp_applied: 32'd40000, exp_clamped: 1'b0, chk_period: 1'b1, lo: 2499, hi: 2501};

        // Reset and idle behaviour
        nrst           = 1'b0;
        bus.swiptAlive = 1'b0;
        bus.f          = 32'd40000;
        wait_neg(3);
        check_reset_outputs("reset");
        nrst = 1'b1;
        wait_neg(5);
        check("idle vco", 32'(bus.vco), 32'd0);
        check("idle state", 32'(dut.state_q), 32'(IDLE));

        // Start at 40 kHz: increment, first partial period, then a valid one
        bus.swiptAlive = 1'b1;
        wait_neg(3);
        check("start inc", dut.inc_q, INC_40K);
        check("start f_applied", bus.f_applied, 32'd40000);
        wait_rise("start rise1 timeout", 5000);
        @(negedge clk);
        check("valid after rise1", 32'(bus.period_valid), 32'd0);
        wait_rise("start rise2 timeout", 5000);
        @(negedge clk);
        check("valid after rise2", 32'(bus.period_valid), 32'd1);
        check_range("period 40k", int'(bus.period), 2499, 2501);

        // Vector table through the scoreboard queue
        for (int i = 0; i < 8; i++) begin
            bus.f = vecs[i].f;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            cur = exp_q.pop_front();
            check($sformatf("clamped f=%0d", cur.f), 32'(bus.clamped), 32'(cur.exp_clamped));
            if (cur.chk_period) begin
                wait_applied($sformatf("f_applied f=%0d", cur.f), cur.exp_applied, 12000);
                wait_rise("vec rise1 timeout", 12000);
                wait_rise("vec rise2 timeout", 12000);
                @(negedge clk);
                check_range($sformatf("period f=%0d", cur.f), int'(bus.period), cur.lo, cur.hi);
                check($sformatf("valid f=%0d", cur.f), 32'(bus.period_valid), 32'd1);
            end
        end

        // Step 40k -> 50k during the high phase: change lands exactly on the wrap
        wait_rise("step rise timeout", 5000);
        bus.f        = 32'd50000;
        hi_cnt       = 1;
        early_change = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.vco !== 1'b1) break;
            hi_cnt++;
            if (bus.f_applied !== 32'd40000) early_change = 1'b1;
        end
        check("step no early change", 32'(early_change), 32'd0);
        check("step f_applied at wrap", bus.f_applied, 32'd50000);
        check_range("step old high phase", hi_cnt, 1249, 1251);
        wait_rise("step rise1 timeout", 5000);
        wait_rise("step rise2 timeout", 5000);
        @(negedge clk);
        check_range("step new period", int'(bus.period), 1999, 2001);

        // Stop mid-high-phase: full high pulse, then IDLE
        wait_rise("stop rise timeout", 5000);
        hi_cnt = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 100) bus.swiptAlive = 1'b0;
            @(negedge clk);
            if (i == 100) check("stop state", 32'(dut.state_q), 32'(STOP));
            if (bus.vco !== 1'b1) break;
            hi_cnt++;
        end
        check_range("stop high phase", hi_cnt, 999, 1001);
        check("stop idle", 32'(dut.state_q), 32'(IDLE));
        check("stop period_valid", 32'(bus.period_valid), 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.vco !== 1'b0 || bus.vco_rise !== 1'b0) quiet = 1'b0;
        end
        check("stop quiet", 32'(quiet), 32'd1);

        // Re-assert during STOP before the wrap: continuous accumulation
        bus.swiptAlive = 1'b1;
        wait_rise("resume rise timeout", 5000);
        prev_acc = dut.acc_q;
        hi_cnt   = 1;
        cont_ok  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 50) bus.swiptAlive = 1'b0;
            if (i == 60) bus.swiptAlive = 1'b1;
            @(negedge clk);
            if (dut.acc_q !== prev_acc + INC_50K) cont_ok = 1'b0;
            prev_acc = dut.acc_q;
            if (i == 50) check("resume in stop", 32'(dut.state_q), 32'(STOP));
            if (i == 60) check("resume in run", 32'(dut.state_q), 32'(RUN));
            if (bus.vco !== 1'b1) break;
            hi_cnt++;
        end
        check("resume acc continuity", 32'(cont_ok), 32'd1);
        check_range("resume high phase", hi_cnt, 999, 1001);
        check("resume state after wrap", 32'(dut.state_q), 32'(RUN));

        // One-cycle reset mid-RUN, then restart at the default frequency
        wait_neg(300);
        nrst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun reset");
        nrst = 1'b1;
        @(negedge clk);
        check("restart state", 32'(dut.state_q), 32'(RUN));
        check("restart f_applied", bus.f_applied, 32'd40000);
        check("restart inc", dut.inc_q, INC_40K);
        wait_rise("restart rise timeout", 5000);
        check("restart vco high", 32'(bus.vco), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_nco.md
FREQ_NCO -- requirements
Module: freq_nco

Interface
REQ-001 Parameter FCLK_HZ, default 100000000, frequency of clk in Hz.
REQ-002 Parameter F_DEFAULT, default 32'h9C40 (40 kHz), frequency applied out of reset.
REQ-003 Parameter F_MIN, default 20000, lower clamp bound in Hz.
REQ-004 Parameter F_MAX, default 60000, upper clamp bound in Hz.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 nrst  input  1  reset, synchronous, active-low.
REQ-007 swiptAlive  input  1  run enable; high starts the oscillator, low requests a glitch-free stop.
REQ-008 f  input  32  requested output frequency in Hz, from the loop-filter stage, unsigned, may change on any cycle.
REQ-009 vco  output  1  synthesized square wave, equal to accumulator bit 31.
REQ-010 vco_rise  output  1  one-cycle pulse in the cycle vco goes 0->1.
REQ-011 f_applied  output  32  clamped frequency currently driving the accumulator.
REQ-012 clamped  output  1  high while the pipelined request lies outside [F_MIN, F_MAX].
REQ-013 period  output  32  clk cycles between the last two vco rises.
REQ-014 period_valid  output  1  high once period holds a full measured cycle.

Function
REQ-015 Request pipeline: cycle 1 registers f; cycle 2 clamps it to [F_MIN, F_MAX] and sets clamped; cycle 3 registers inc_next = (f_clamped * INC_K) >> 24, where INC_K = round(2^56 / FCLK_HZ) is a 32-bit localparam and the product is 64 bits wide.
REQ-016 Accumulator: 32-bit acc, acc <= acc + inc each RUN/STOP cycle, modulo 2^32; wrap is the carry out of bit 31.
REQ-017 inc and f_applied load from inc_next and f_clamped only in a wrap cycle or on entry to RUN, so a vco half-period never changes mid-cycle.
REQ-018 FSM states IDLE, RUN, STOP; reset state IDLE.
REQ-019 IDLE: acc = 0, vco = 0, no rise pulses; when swiptAlive = 1, load inc and go to RUN the next cycle.
REQ-020 RUN: accumulate; when swiptAlive = 0, go to STOP.
REQ-021 STOP: keep accumulating until the next wrap; at the wrap, clear acc and go to IDLE; if swiptAlive returns high before the wrap, go back to RUN without clearing acc.
REQ-022 Both wrap and a swiptAlive change in the same STOP cycle: the wrap wins (clear and go to IDLE); restart follows from IDLE.
REQ-023 period counter: increments each non-IDLE cycle and saturates at 32'hFFFFFFFF; on vco_rise, period <= counter and counter <= 1.
REQ-024 period_valid is set on the second vco_rise after leaving IDLE and cleared on entry to IDLE.
REQ-025 vco, vco_rise, period and period_valid are registered outputs; no combinational path from f or swiptAlive to any output.

Reset
REQ-026 nrst = 0 in any state, including mid-cycle, forces at the next edge: state IDLE, acc 0, vco 0, vco_rise 0, inc and inc_next = increment of F_DEFAULT, f_applied = F_DEFAULT, clamped 0, period 0, period_valid 0, counter 0.

Structure
REQ-027 Shared package holds the state enumeration, the 24-bit scale shift, and the default F_DEFAULT, F_MIN and F_MAX values.
REQ-028 One sub-module, nco_inc_calc, holds the registered clamp and multiply pipeline (REQ-015); freq_nco holds the FSM, accumulator and period counter.

Verification
REQ-029 FCLK_HZ = 1e8, f = 40000, swiptAlive = 1 -> inc = 1717986, period = 2500 +/- 1, period_valid after the second rise.
REQ-030 f = 0 then f = 70000 -> clamped = 1; f_applied = 20000 (period 5000 +/- 1), then 60000 (period 1666 or 1667).
REQ-031 f steps from 40000 to 50000 while vco = 1 -> current cycle completes at the old rate; f_applied changes exactly at the wrap; the next period is 2000 +/- 1.
REQ-032 swiptAlive drops mid-high-phase -> vco finishes its cycle, falls at the wrap, state = IDLE, no truncated high pulse; period_valid = 0.
REQ-033 nrst = 0 for 1 cycle mid-RUN -> all outputs at REQ-026 values the next cycle; with swiptAlive = 1 the block restarts at F_DEFAULT.
REQ-034 swiptAlive re-asserted during STOP before the wrap -> returns to RUN with no acc discontinuity and no vco glitch.
